// File: rtl/tx_frame_arbiter_pkg.sv
// Shared definitions for the TX frame arbiter: FSM state encoding and default timing constants.
package tx_frame_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StLaunch   = 3'd1,
        StWaitBusy = 3'd2,
        StWaitDone = 3'd3,
        StGap      = 3'd4
    } arb_state_e;

    // 96-bit inter-frame gap at one byte per 125 MHz cycle.
    localparam int unsigned DefaultGapCycles = 12;
    localparam int unsigned DefaultBusyTmo   = 16;

    localparam int unsigned IdxW = 2;
    localparam int unsigned CntW = 16;

endpackage

// File: rtl/tx_frame_arbiter_rr_pick.sv
// Combinational round-robin pick over the non-priority requesters, starting after rr_ptr.
module tx_frame_arbiter_rr_pick
    import tx_frame_arbiter_pkg::*;
#(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned PRIO_IDX = 0
) (
    input  logic [NREQ-1:0] req_mask,
    input  logic [IdxW-1:0] rr_ptr,
    output logic            valid,
    output logic [IdxW-1:0] win
);

    int idx;

    always_comb begin
        valid = 1'b0;
        win   = '0;
        idx   = 0;
        // Scan farthest-first so the candidate nearest to rr_ptr+1 is the last one assigned.
        for (int k = int'(NREQ); k > 0; k--) begin
            idx = (int'(rr_ptr) + k) % int'(NREQ);
            if (idx != int'(PRIO_IDX) && req_mask[idx[IdxW-1:0]]) begin
                valid = 1'b1;
                win   = idx[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Shares one Ethernet frame builder among NREQ sources: strict priority with a starvation
// limit, round-robin for the rest, inter-frame gap and busy-rise timeout.
module tx_frame_arbiter
    import tx_frame_arbiter_pkg::*;
#(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned PRIO_IDX   = 0,
    parameter int unsigned MAX_CONSEC = 4,
    parameter int unsigned GAP_CYCLES = DefaultGapCycles,
    parameter int unsigned BUSY_TMO   = DefaultBusyTmo
) (
    input  logic                 clk125MHz,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   seg_num_in,
    input  logic [8*NREQ-1:0]    txid_in,
    input  logic [8*NREQ-1:0]    aux_in,
    input  logic                 busy,
    output logic [NREQ-1:0]      ack,
    output logic                 start_sending,
    output logic [15:0]          segment_num,
    output logic [7:0]           txid,
    output logic [7:0]           aux,
    output logic [IdxW-1:0]      grant_id,
    output logic                 tmo_err,
    output logic [31:0]          frames_sent
);

    localparam int unsigned ConsW = $clog2(MAX_CONSEC + 1);

    arb_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [ConsW-1:0] consec_q, consec_d;
    logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             start_q, start_d;
    logic [15:0]      seg_q, seg_d;
    logic [7:0]       txid_q, txid_d;
    logic [7:0]       aux_q, aux_d;
    logic [IdxW-1:0]  grant_q, grant_d;
    logic             tmo_q, tmo_d;
    logic [31:0]      frames_q, frames_d;

    logic [NREQ-1:0]  others;
    logic             prio_sel;
    logic             rr_valid;
    logic [IdxW-1:0]  rr_win;
    logic [IdxW-1:0]  win;

    always_comb begin
        others           = req;
        others[PRIO_IDX] = 1'b0;
        prio_sel = req[PRIO_IDX] && (others == '0 || consec_q < ConsW'(MAX_CONSEC));
    end

    tx_frame_arbiter_rr_pick #(
        .NREQ     (NREQ),
        .PRIO_IDX (PRIO_IDX)
    ) u_rr_pick (
        .req_mask (others),
        .rr_ptr   (rr_ptr_q),
        .valid    (rr_valid),
        .win      (rr_win)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        consec_d = consec_q;
        rr_ptr_d = rr_ptr_q;
        ack_d    = '0;
        start_d  = 1'b0;
        seg_d    = seg_q;
        txid_d   = txid_q;
        aux_d    = aux_q;
        grant_d  = grant_q;
        tmo_d    = 1'b0;
        frames_d = frames_q;
        win      = '0;

        unique case (state_q)
            StIdle: begin
                // Launch outputs and field latches are registered here so they are all
                // valid together during the single LAUNCH cycle.
                if (!busy && (prio_sel || rr_valid)) begin
                    if (prio_sel) begin
                        win = IdxW'(PRIO_IDX);
                        if (others != '0 && consec_q < ConsW'(MAX_CONSEC)) begin
                            consec_d = consec_q + 1'b1;
                        end
                    end else begin
                        win      = rr_win;
                        rr_ptr_d = rr_win;
                        consec_d = '0;
                    end
                    state_d  = StLaunch;
                    start_d  = 1'b1;
                    ack_d    = NREQ'(1) << win;
                    seg_d    = seg_num_in[16*win +: 16];
                    txid_d   = txid_in[8*win +: 8];
                    aux_d    = aux_in[8*win +: 8];
                    grant_d  = win;
                    frames_d = frames_q + 32'd1;
                end
            end
            StLaunch: begin
                state_d = StWaitBusy;
                cnt_d   = '0;
            end
            StWaitBusy: begin
                if (busy) begin
                    state_d = StWaitDone;
                end else if (cnt_q == CntW'(BUSY_TMO - 1)) begin
                    state_d = StGap;
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!busy) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk125MHz) begin
        if (RST) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            consec_q <= '0;
            rr_ptr_q <= IdxW'(NREQ - 1);
            ack_q    <= '0;
            start_q  <= 1'b0;
            seg_q    <= '0;
            txid_q   <= '0;
            aux_q    <= '0;
            grant_q  <= '0;
            tmo_q    <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            consec_q <= consec_d;
            rr_ptr_q <= rr_ptr_d;
            ack_q    <= ack_d;
            start_q  <= start_d;
            seg_q    <= seg_d;
            txid_q   <= txid_d;
            aux_q    <= aux_d;
            grant_q  <= grant_d;
            tmo_q    <= tmo_d;
            frames_q <= frames_d;
        end
    end

    assign ack           = ack_q;
    assign start_sending = start_q;
    assign segment_num   = seg_q;
    assign txid          = txid_q;
    assign aux           = aux_q;
    assign grant_id      = grant_q;
    assign tmo_err       = tmo_q;
    assign frames_sent   = frames_q;

endmodule
